// File: rtl/bist_pkg.sv
// Shared definitions for the BIST controller: default CUT widths,
// feedback tap positions for the pattern LFSR and the response MISR,
// and the controller state encoding.
package bist_pkg;

    // Default CUT widths.
    localparam int PI_W_DEF = 35;
    localparam int PO_W_DEF = 49;

    // LFSR polynomial x^35 + x^33 + 1 (Fibonacci, shift-left): feedback
    // into bit 0 is lfsr[34] ^ lfsr[32].
    localparam int LFSR_TAP_A = 34;
    localparam int LFSR_TAP_B = 32;

    // MISR polynomial x^49 + x^40 + 1 (Fibonacci, shift-left): feedback
    // into bit 0 is misr[48] ^ misr[39].
    localparam int MISR_TAP_A = 48;
    localparam int MISR_TAP_B = 39;

    // Bit 0 of the encoding is set exactly in the states that drive the
    // LFSR onto the CUT. The cut_pi mux select is then a single flop
    // output, so it cannot glitch relative to the state register.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b11,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register. Compacts one W-bit response word per
// enabled clock into a running signature; clr restarts from zero.
module bist_misr
    import bist_pkg::*;
#(
    parameter int W     = PO_W_DEF,
    parameter int TAP_A = MISR_TAP_A,
    parameter int TAP_B = MISR_TAP_B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] sig
);

    // Signature register: clear has priority over capture.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[W-2:0], sig[TAP_A] ^ sig[TAP_B]} ^ d;
        end
    end

endmodule

// File: rtl/bist_ctrl.sv
// BIST controller between the chip pins and the CUT. System mode passes
// pi_ext through; BIST mode applies LFSR patterns, compacts the CUT
// responses in a MISR and reports done/pass against a golden signature.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int              PI_W         = PI_W_DEF,
    parameter int              PO_W         = PO_W_DEF,
    parameter int              NUM_PATTERNS = 2000,
    parameter logic [PI_W-1:0] LFSR_SEED    = {{(PI_W-1){1'b0}}, 1'b1},
    parameter logic [PO_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bistmode,
    input  logic [PI_W-1:0] pi_ext,
    input  logic [PO_W-1:0] cut_po,
    output logic [PI_W-1:0] cut_pi,
    output logic            bistdone,
    output logic            bistpass
);

    // The counter only has to reach NUM_PATTERNS-1; it holds there on the
    // final RUN edge instead of wrapping.
    localparam int              CNT_W    = $clog2(NUM_PATTERNS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 1);

    state_e           state;
    state_e           state_nxt;
    logic [PI_W-1:0]  lfsr;
    logic [CNT_W-1:0] cnt;
    logic [PO_W-1:0]  misr;
    logic [PO_W-1:0]  misr_nxt;
    logic             start;
    logic             shift_en;
    logic             capture;
    logic             finish;

    // A run starts from IDLE; every other transition is gated by bistmode
    // so that dropping it aborts immediately, even on the FLUSH edge.
    assign start    = (state == IDLE) && bistmode;
    assign shift_en = (state == RUN) && bistmode;
    assign capture  = ((state == RUN) || (state == FLUSH)) && bistmode;
    assign finish   = (state == FLUSH) && bistmode;

    // Look-ahead of the MISR update, so the pass flag can be registered on
    // the same edge as the final capture.
    assign misr_nxt = {misr[PO_W-2:0], misr[MISR_TAP_A] ^ misr[MISR_TAP_B]} ^ cut_po;

    // Next-state decode.
    // NOTE: the default assignment at the top keeps every path assigned, so
    // no latch is inferred for state_nxt.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bistmode) state_nxt = RUN;
            end
            RUN: begin
                if (!bistmode)            state_nxt = IDLE;
                else if (cnt == CNT_LAST) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (!bistmode) state_nxt = IDLE;
                else           state_nxt = DONE;
            end
            DONE: begin
                if (!bistmode) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pattern generator: reseeded at run start, advances once per RUN edge
    // and holds through FLUSH and DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else if (start) begin
            lfsr <= LFSR_SEED;
        end else if (shift_en) begin
            lfsr <= {lfsr[PI_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
        end
    end

    // Pattern counter: counts RUN edges and saturates at the last pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (shift_en && (cnt != CNT_LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    bist_misr #(
        .W     (PO_W),
        .TAP_A (MISR_TAP_A),
        .TAP_B (MISR_TAP_B)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (capture),
        .d   (cut_po),
        .sig (misr)
    );

    // Result flags: both set on the FLUSH capture, both cleared on leaving
    // DONE, so they always change on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bistdone <= 1'b0;
            bistpass <= 1'b0;
        end else if (finish) begin
            bistdone <= 1'b1;
            bistpass <= (misr_nxt == GOLDEN_SIG);
        end else if ((state == DONE) && !bistmode) begin
            bistdone <= 1'b0;
            bistpass <= 1'b0;
        end
    end

    // CUT input mux, selected directly by state bit 0 (RUN or FLUSH).
    assign cut_pi = state[0] ? lfsr : pi_ext;

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed bench for bist_ctrl with an 8-pattern run. The stub CUT echoes
// cut_pi into the low PO bits, with an optional stuck-at-1 on cut_po[0].
// With seed 1 the patterns are 1<<k for k = 0..8 (no feedback reaches bit
// 0 yet), and the MISR steps m = (m << 1) ^ (1 << k) give 1,0,4,0,16,0,64,
// 0,0x100, so the fault-free signature is 49'h100. With the fault the
// signature is 49'h1FF.
module tb_bist_ctrl;

    localparam int              PI_W = 35;
    localparam int              PO_W = 49;
    localparam int              NP   = 8;
    localparam logic [PI_W-1:0] SEED = 35'h1;
    localparam logic [PO_W-1:0] GOLD = 49'h100;

    logic            clk;
    logic            rst;
    logic            bistmode;
    logic [PI_W-1:0] pi_ext;
    logic [PO_W-1:0] cut_po;
    logic [PI_W-1:0] cut_pi;
    logic            bistdone;
    logic            bistpass;
    logic            fault;

    int checks;
    int errors;

    bist_ctrl #(
        .PI_W         (PI_W),
        .PO_W         (PO_W),
        .NUM_PATTERNS (NP),
        .LFSR_SEED    (SEED),
        .GOLDEN_SIG   (GOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bistmode (bistmode),
        .pi_ext   (pi_ext),
        .cut_po   (cut_po),
        .cut_pi   (cut_pi),
        .bistdone (bistdone),
        .bistpass (bistpass)
    );

    // Stub CUT.
    assign cut_po = {14'b0, cut_pi} | {{(PO_W-1){1'b0}}, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full run from IDLE; called at a negedge with rst high. Edge 0 is the
    // IDLE->RUN edge, done must appear exactly after edge NP+1.
    task automatic do_run(input string tag, input logic exp_pass);
        logic [PI_W-1:0] exp_lfsr;
        exp_lfsr = SEED;
        bistmode = 1'b1;
        for (int e = 0; e <= NP + 1; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e >= 1 && e <= NP)
                exp_lfsr = {exp_lfsr[33:0], exp_lfsr[34] ^ exp_lfsr[32]};
            if (e <= NP) begin
                checks++;
                if (cut_pi !== exp_lfsr) begin
                    errors++;
                    $display("FAIL %s cut_pi edge %0d: got %h expected %h", tag, e, cut_pi, exp_lfsr);
                end
                checks++;
                if (bistdone !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early bistdone edge %0d: got %b expected 0", tag, e, bistdone);
                end
            end else begin
                checks++;
                if (bistdone !== 1'b1) begin
                    errors++;
                    $display("FAIL %s bistdone edge %0d: got %b expected 1", tag, e, bistdone);
                end
                checks++;
                if (bistpass !== exp_pass) begin
                    errors++;
                    $display("FAIL %s bistpass: got %b expected %b", tag, bistpass, exp_pass);
                end
                checks++;
                if (cut_pi !== pi_ext) begin
                    errors++;
                    $display("FAIL %s cut_pi in done: got %h expected %h", tag, cut_pi, pi_ext);
                end
            end
        end
    endtask

    task automatic test_reset();
        bistmode = 1'b1;
        pi_ext   = 35'h5_5555_5555;
        repeat (3) @(negedge clk);
        checks++;
        if (cut_pi !== 35'h5_5555_5555) begin
            errors++;
            $display("FAIL reset cut_pi: got %h expected %h", cut_pi, 35'h5_5555_5555);
        end
        checks++;
        if (bistdone !== 1'b0 || bistpass !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: got done=%b pass=%b expected 0 0", bistdone, bistpass);
        end
        bistmode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cut_pi !== pi_ext) begin
            errors++;
            $display("FAIL idle cut_pi: got %h expected %h", cut_pi, pi_ext);
        end
    endtask

    task automatic test_fault_free();
        pi_ext = 35'h2_AAAA_AAAA;
        do_run("fault_free", 1'b1);
    endtask

    // bistmode still high in DONE: no rerun; dropping it clears the flags.
    task automatic test_done_hold();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bistdone !== 1'b1 || bistpass !== 1'b1 || cut_pi !== pi_ext) begin
                errors++;
                $display("FAIL done_hold: got done=%b pass=%b cut_pi=%h expected 1 1 %h",
                         bistdone, bistpass, cut_pi, pi_ext);
            end
        end
        bistmode = 1'b0;
        @(negedge clk);
        checks++;
        if (bistdone !== 1'b0 || bistpass !== 1'b0) begin
            errors++;
            $display("FAIL done_exit: got done=%b pass=%b expected 0 0", bistdone, bistpass);
        end
    endtask

    task automatic test_faulty();
        fault = 1'b1;
        do_run("faulty", 1'b0);
        bistmode = 1'b0;
        @(negedge clk);
        fault = 1'b0;
    endtask

    task automatic test_abort();
        logic seen_done;
        pi_ext   = 35'h1_2345_6789;
        bistmode = 1'b1;
        repeat (5) @(negedge clk);      // edges 0..4
        bistmode = 1'b0;
        @(negedge clk);
        checks++;
        if (cut_pi !== pi_ext || bistdone !== 1'b0) begin
            errors++;
            $display("FAIL abort: got cut_pi=%h done=%b expected %h 0", cut_pi, bistdone, pi_ext);
        end
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bistdone !== 1'b0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL abort bistdone asserted: got 1 expected 0");
        end
        do_run("abort_rerun", 1'b1);
        bistmode = 1'b0;
        @(negedge clk);
    endtask

    // Abort on the FLUSH edge wins over completion.
    task automatic test_flush_abort();
        logic [PI_W-1:0] exp_flush;
        exp_flush = 35'h100;
        bistmode  = 1'b1;
        repeat (NP + 1) @(negedge clk); // edges 0..NP, now in FLUSH
        checks++;
        if (cut_pi !== exp_flush) begin
            errors++;
            $display("FAIL flush cut_pi: got %h expected %h", cut_pi, exp_flush);
        end
        bistmode = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bistdone !== 1'b0 || cut_pi !== pi_ext) begin
                errors++;
                $display("FAIL flush_abort: got done=%b cut_pi=%h expected 0 %h",
                         bistdone, cut_pi, pi_ext);
            end
        end
    endtask

    task automatic test_async_reset();
        bistmode = 1'b1;
        repeat (6) @(posedge clk);      // edges 0..5
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (cut_pi !== pi_ext || bistdone !== 1'b0 || bistpass !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got cut_pi=%h done=%b pass=%b expected %h 0 0",
                     cut_pi, bistdone, bistpass, pi_ext);
        end
        @(negedge clk);
        rst = 1'b1;
        do_run("reset_rerun", 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b0;
            bistmode = 1'b1;
            @(negedge clk);
            checks++;
            if (bistdone !== 1'b0 || cut_pi !== pi_ext) begin
                errors++;
                $display("FAIL b2b reset %0d: got done=%b cut_pi=%h expected 0 %h",
                         i, bistdone, cut_pi, pi_ext);
            end
            rst = 1'b1;
            do_run((i == 0) ? "b2b_run0" : "b2b_run1", 1'b1);
        end
        bistmode = 1'b0;
        @(negedge clk);
        checks++;
        if (bistdone !== 1'b0 || bistpass !== 1'b0) begin
            errors++;
            $display("FAIL b2b done_exit: got done=%b pass=%b expected 0 0", bistdone, bistpass);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        bistmode = 1'b0;
        pi_ext   = '0;
        fault    = 1'b0;
        test_reset();
        test_fault_free();
        test_done_hold();
        test_faulty();
        test_abort();
        test_flush_abort();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
